// File: rtl/pipe_regs_if.sv
// ============================================================================
// Module   : pipe_regs_if
// Brief    : Signal bundle between hazard unit / fetch-decode datapath and the
//            pipeline register bank (PC, IF/ID, ID/EX).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface pipe_regs_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 10,
    parameter int CNT_W  = 32
);
    // hazard unit controls
    logic              stall_if;
    logic              stall_id;
    logic              flush_ex;
    logic              clr_id;

    // fetch stage
    logic [DATA_W-1:0] pc_next;
    logic [DATA_W-1:0] pc_if;
    logic [DATA_W-1:0] instr_if;
    logic [DATA_W-1:0] pc_plus4_if;

    // IF/ID latch
    logic [DATA_W-1:0] instr_id;
    logic [DATA_W-1:0] pc_plus4_id;
    logic              valid_id;

    // decode stage results
    logic [CTRL_W-1:0] ctrl_id;
    logic [DATA_W-1:0] rd1_id;
    logic [DATA_W-1:0] rd2_id;
    logic [4:0]        rs_id;
    logic [4:0]        rt_id;
    logic [4:0]        rd_id;
    logic [DATA_W-1:0] imm_id;

    // ID/EX latch
    logic [CTRL_W-1:0] ctrl_ex;
    logic [DATA_W-1:0] rd1_ex;
    logic [DATA_W-1:0] rd2_ex;
    logic [4:0]        rs_ex;
    logic [4:0]        rt_ex;
    logic [4:0]        rd_ex;
    logic [DATA_W-1:0] imm_ex;
    logic              valid_ex;

    // performance counters
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  bubble_cnt;

    // datapath / hazard-unit side
    modport master (
        output stall_if, stall_id, flush_ex, clr_id,
        output pc_next, instr_if, pc_plus4_if,
        output ctrl_id, rd1_id, rd2_id, rs_id, rt_id, rd_id, imm_id,
        input  pc_if, instr_id, pc_plus4_id, valid_id,
        input  ctrl_ex, rd1_ex, rd2_ex, rs_ex, rt_ex, rd_ex, imm_ex, valid_ex,
        input  stall_cnt, bubble_cnt
    );

    // register bank side
    modport slave (
        input  stall_if, stall_id, flush_ex, clr_id,
        input  pc_next, instr_if, pc_plus4_if,
        input  ctrl_id, rd1_id, rd2_id, rs_id, rt_id, rd_id, imm_id,
        output pc_if, instr_id, pc_plus4_id, valid_id,
        output ctrl_ex, rd1_ex, rd2_ex, rs_ex, rt_ex, rd_ex, imm_ex, valid_ex,
        output stall_cnt, bubble_cnt
    );
endinterface

`default_nettype wire

// File: rtl/pipe_regs.sv
// ============================================================================
// Module   : pipe_regs
// Brief    : PC register, IF/ID and ID/EX latches of the 5-stage MIPS core with
//            stall hold, branch clear and EX bubble insertion. Optional stall /
//            bubble counters enabled by the PIPE_PERF_CNT_EN macro.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_regs #(
    parameter int                 DATA_W   = 32,
    parameter int                 CTRL_W   = 10,
    parameter logic [DATA_W-1:0]  RESET_PC = '0,
    parameter int                 CNT_W    = 32
) (
    input  wire logic     clk,
    input  wire logic     rst,
    pipe_regs_if.slave    bus
);

    // ------------------------------------------------------------------
    // PC register
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (!bus.stall_if) begin
            r_pc <= bus.pc_next;
        end
    end

    assign bus.pc_if = r_pc;

    // ------------------------------------------------------------------
    // IF/ID latch: stall holds, clr squashes the fetched instruction
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_instr_id;
    logic [DATA_W-1:0] r_pc_plus4_id;
    logic              r_valid_id;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr_id    <= '0;
            r_pc_plus4_id <= '0;
            r_valid_id    <= 1'b0;
        end else if (bus.stall_id) begin
            r_instr_id    <= r_instr_id;
            r_pc_plus4_id <= r_pc_plus4_id;
            r_valid_id    <= r_valid_id;
        end else if (bus.clr_id) begin
            r_instr_id    <= '0;
            r_pc_plus4_id <= '0;
            r_valid_id    <= 1'b0;
        end else begin
            r_instr_id    <= bus.instr_if;
            r_pc_plus4_id <= bus.pc_plus4_if;
            r_valid_id    <= 1'b1;
        end
    end

    assign bus.instr_id    = r_instr_id;
    assign bus.pc_plus4_id = r_pc_plus4_id;
    assign bus.valid_id    = r_valid_id;

    // ------------------------------------------------------------------
    // ID/EX latch: never holds; a stalled decode always pairs with a
    // flush, so the downstream stages keep draining behind a bubble.
    // Zeroed ctrl/rd/rt make the bubble write nothing and forward nothing.
    // ------------------------------------------------------------------
    logic [CTRL_W-1:0] r_ctrl_ex;
    logic [DATA_W-1:0] r_rd1_ex;
    logic [DATA_W-1:0] r_rd2_ex;
    logic [4:0]        r_rs_ex;
    logic [4:0]        r_rt_ex;
    logic [4:0]        r_rd_ex;
    logic [DATA_W-1:0] r_imm_ex;
    logic              r_valid_ex;

    always_ff @(posedge clk) begin
        if (rst || bus.flush_ex) begin
            r_ctrl_ex  <= '0;
            r_rd1_ex   <= '0;
            r_rd2_ex   <= '0;
            r_rs_ex    <= '0;
            r_rt_ex    <= '0;
            r_rd_ex    <= '0;
            r_imm_ex   <= '0;
            r_valid_ex <= 1'b0;
        end else begin
            r_ctrl_ex  <= bus.ctrl_id;
            r_rd1_ex   <= bus.rd1_id;
            r_rd2_ex   <= bus.rd2_id;
            r_rs_ex    <= bus.rs_id;
            r_rt_ex    <= bus.rt_id;
            r_rd_ex    <= bus.rd_id;
            r_imm_ex   <= bus.imm_id;
            r_valid_ex <= r_valid_id;
        end
    end

    assign bus.ctrl_ex  = r_ctrl_ex;
    assign bus.rd1_ex   = r_rd1_ex;
    assign bus.rd2_ex   = r_rd2_ex;
    assign bus.rs_ex    = r_rs_ex;
    assign bus.rt_ex    = r_rt_ex;
    assign bus.rd_ex    = r_rd_ex;
    assign bus.imm_ex   = r_imm_ex;
    assign bus.valid_ex = r_valid_ex;

    // ------------------------------------------------------------------
    // Performance counters (saturating)
    // ------------------------------------------------------------------
`ifdef PIPE_PERF_CNT_EN
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (bus.stall_id && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
            end
            if (bus.flush_ex && (r_bubble_cnt != '1)) begin
                r_bubble_cnt <= r_bubble_cnt + c_CNT_ONE;
            end
        end
    end

    assign bus.stall_cnt  = r_stall_cnt;
    assign bus.bubble_cnt = r_bubble_cnt;
`else
    assign bus.stall_cnt  = {CNT_W{1'b0}};
    assign bus.bubble_cnt = {CNT_W{1'b0}};
`endif

endmodule

`default_nettype wire
